seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment scanner, the next generation of the clock display path.
- Takes NUM_DIGITS packed 4-bit codes and scans them onto a shared segment bus (Duan) with one-hot digit selects (Wei).
- New capability: frame-coherent input sampling, leading-zero suppression, per-digit blink, PWM brightness and configurable output polarity.
- Sits between the time/alarm counters and the board LED digits.

Parameters:
- NUM_DIGITS, 8: number of digits scanned; legal range 2..16.
- SCAN_DIV, 50000: clocks per digit slot (1 ms at 50 MHz).
- BLINK_FRAMES, 250: frames per blink half-period.
- PWM_BITS, 3: width of brightness control.
- SEG_ACTIVE_LOW, 1: 1 means Duan bits drive 0 when lit.
- DIG_ACTIVE_LOW, 1: 1 means the selected Wei bit drives 0.
- DEAD_CYCLES, 16: anti-ghost dead time in clocks. Used only with the optional feature.

Ports:
- Clk_50MHz  in  1  system clock.
- Reset  in  1  asynchronous reset, active-high.
- Enable  in  1  scan enable. Low means display dark and counters held.
- Bcd_in  in  4*NUM_DIGITS  packed digit codes; digit 0 is in bits [3:0] and is the rightmost digit.
- Dp_in  in  NUM_DIGITS  per-digit decimal point request.
- Blank_lz  in  1  leading-zero suppression enable.
- Blink_mask  in  NUM_DIGITS  digits that blink.
- Bright  in  PWM_BITS  brightness level; duty = (Bright+1)/2^PWM_BITS.
- Duan  out  8  segment bus: [7]=dp, [6:0]=g..a.
- Wei  out  NUM_DIGITS  one-hot digit select.
- Frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock, Clk_50MHz. Reset is asynchronous and active-high.
- Reset values:
  - Duan and Wei inactive (all 1s when the corresponding active-low parameter is 1).
  - Frame_done=0; prescaler=0; idx=NUM_DIGITS-1.
  - Shadow codes all 4'hF (blank).
  - blink_phase=0; blink counter=0; pwm counter=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1 while Enable=1.
  - tick is asserted when the count equals SCAN_DIV-1; the count then wraps to 0.
- Digit index and frame start:
  - idx advances on tick and wraps NUM_DIGITS-1 to 0.
  - The tick that wraps idx to 0 loads the shadow registers (codes, Dp_in, Blink_mask, computed lz-blank vector) and pulses Frame_done in the same cycle.
  - Because idx resets to NUM_DIGITS-1, the first tick after reset loads the shadow registers and starts digit 0.
- Frame coherence: input changes mid-frame are invisible until the next frame load.
- Code map (4-bit):
  - 0-9: decimal digits.
  - 10: dash (segment g).
  - 11: 'E'.
  - 12: 'r'.
  - 13: 'H'.
  - 14-15: blank.
- Leading-zero suppression (Blank_lz=1 at load): scanning from digit NUM_DIGITS-1 downward, each digit with code 0 is blanked until the first nonzero code. Digit 0 is never blanked. DP still follows Dp_in.
- Blink: the blink counter counts Frame_done pulses and toggles blink_phase every BLINK_FRAMES frames. While blink_phase=1, masked digits are fully dark (Wei bit inactive).
- PWM:
  - The pwm counter, PWM_BITS wide, is free-running while Enable=1.
  - The current digit is lit only while the count is ≤ Bright.
  - Bright = all 1s gives 100% duty.
- Output timing: Duan and Wei are registered, one cycle after the state that selects them.
- Enable=0: next cycle Duan and Wei are inactive. All counters hold; Frame_done stays 0. Scanning resumes from the held state.
- Reset asserted mid-slot: all outputs go to reset values asynchronously. No partial frame is completed.

Optional Feature:
- Macro SEG_SCAN_DEADTIME_EN.
- Defined: for prescaler counts 0..DEAD_CYCLES-1 of every slot, Wei is forced inactive and Duan carries the new digit's pattern (anti-ghosting). DEAD_CYCLES must be < SCAN_DIV.
- Not defined: Wei switches directly at slot boundaries; DEAD_CYCLES is ignored.

Decomposition:
- Package seg_scan_pkg holds:
  - code constants: CODE_DASH=10, CODE_E=11, CODE_R=12, CODE_H=13, CODE_BLANK=15;
  - the 7-bit active-high segment patterns.
- Sub-module seg7_decode: combinational code-to-7-segment decode, active-high. Polarity inversion is applied in seg_scan_ctrl.

Test Plan:
1. NUM_DIGITS=8, SCAN_DIV=4, Bcd_in=32'h12345678, Dp_in=0, Bright=7, active-low outputs, release reset:
   - Wei goes 8'hFE, 8'hFD, ... each 4 clocks.
   - The digit-0 slot shows Duan=8'h80 ('8').
   - Frame_done pulses every 32 clocks.
2. Bcd_in=32'h00000042, Blank_lz=1:
   - digits 7..2 show Duan=8'hFF; digits 1 and 0 show '4' and '2'.
   - With Bcd_in=0, only digit 0 lit, showing '0'.
3. Change Bcd_in at slot 3 of a frame: slots 3-7 still show old codes; new codes appear from the slot after the next Frame_done.
4. Blink_mask=8'h03, BLINK_FRAMES=2: digits 0-1 dark in frames 2-3, lit in frames 4-5; other digits always lit.
5. PWM_BITS=3, Bright=2: the selected Wei bit is active 3 of every 8 clocks. Bright=7 gives continuous activity.
6. Reset mid-slot, Enable low, and (with SEG_SCAN_DEADTIME_EN, DEAD_CYCLES=2, SCAN_DIV=8):
   - Reset mid-slot: Duan=8'hFF and Wei all 1s immediately; Frame_done=0.
   - Enable low: outputs dark and counters frozen.
   - With the macro: Wei inactive for the first 2 clocks of each slot.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared code constants and active-high segment patterns for the seven-segment scanner.
// Segment bit order is g..a, i.e. bit 0 drives segment a.
package seg_scan_pkg;

  localparam logic [3:0] CODE_DASH  = 4'd10;
  localparam logic [3:0] CODE_E     = 4'd11;
  localparam logic [3:0] CODE_R     = 4'd12;
  localparam logic [3:0] CODE_H     = 4'd13;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_H     = 7'h76;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry k holds the pattern for decimal digit k.
  localparam logic [9:0][6:0] SEG_DIGIT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to active-high 7-segment decode (g..a).
// Codes 14 and 15 are blank; polarity is applied by the caller.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (code_i <= 4'd9) begin
      seg_o = SEG_DIGIT[code_i];
    end else begin
      case (code_i)
        CODE_DASH:  seg_o = SEG_DASH;
        CODE_E:     seg_o = SEG_E;
        CODE_R:     seg_o = SEG_R;
        CODE_H:     seg_o = SEG_H;
        CODE_BLANK: seg_o = SEG_BLANK;
        default:    seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: frame-coherent shadow load, leading-zero blanking,
// per-digit blink, PWM brightness. Define SEG_SCAN_DEADTIME_EN for anti-ghost dead time.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 250,
  parameter int PWM_BITS       = 3,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int DEAD_CYCLES    = 16
) (
  input  logic                    Clk_50MHz,
  input  logic                    Reset,
  input  logic                    Enable,
  input  logic [4*NUM_DIGITS-1:0] Bcd_in,
  input  logic [NUM_DIGITS-1:0]   Dp_in,
  input  logic                    Blank_lz,
  input  logic [NUM_DIGITS-1:0]   Blink_mask,
  input  logic [PWM_BITS-1:0]     Bright,
  output logic [7:0]              Duan,
  output logic [NUM_DIGITS-1:0]   Wei,
  output logic                    Frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);
  localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(SCAN_DIV - 1);
  localparam logic [PRE_W-1:0] DEAD_LIM = PRE_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0] BLK_MAX  = BLK_W'(BLINK_FRAMES);
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? '1 : '0;
`ifdef SEG_SCAN_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] code_q, code_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic [NUM_DIGITS-1:0]   lz_q, lz_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0]     pwm_q, pwm_d;
  logic                    frame_done_q, frame_done_d;
  logic [7:0]              duan_q, duan_d;
  logic [NUM_DIGITS-1:0]   wei_q, wei_d;

  logic       tick, lit, dead_win;
  logic [3:0] cur_code;
  logic [6:0] cur_seg;

  // zero_above[d] is set when digits d..NUM_DIGITS-1 all carry code 0.
  logic [NUM_DIGITS:1] zero_above;
  assign zero_above[NUM_DIGITS] = 1'b1;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign zero_above[gi] = zero_above[gi+1] & (Bcd_in[4*gi +: 4] == 4'h0);
  end

  assign tick     = Enable && (presc_q == PRE_MAX);
  assign cur_code = code_q[{idx_q, 2'b00} +: 4];
  assign lit      = Enable && !(blink_phase_q && blink_q[idx_q]) && (pwm_q <= Bright);
  assign dead_win = DEAD_EN && (presc_q < DEAD_LIM);

  seg7_decode u_decode (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    code_d        = code_q;
    dp_d          = dp_q;
    blink_d       = blink_q;
    lz_d          = lz_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    pwm_d         = pwm_q;
    frame_done_d  = 1'b0;
    if (Enable) begin
      pwm_d = pwm_q + 1'b1;
      if (!tick) begin
        presc_d = presc_q + 1'b1;
      end else begin
        presc_d = '0;
        if (idx_q != IDX_MAX) begin
          idx_d = idx_q + 1'b1;
        end else begin
          idx_d        = '0;
          code_d       = Bcd_in;
          dp_d         = Dp_in;
          blink_d      = Blink_mask;
          lz_d         = Blank_lz ? {zero_above[NUM_DIGITS-1:1], 1'b0} : '0;
          frame_done_d = 1'b1;
          // blink_cnt_q is the number of frames already started in the current half-period.
          if (blink_cnt_q == BLK_MAX) begin
            blink_cnt_d   = BLK_W'(1);
            blink_phase_d = ~blink_phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
    end
    duan_d = (lit ? {dp_q[idx_q], lz_q[idx_q] ? 7'h00 : cur_seg} : 8'h00) ^ SEG_OFF;
    wei_d  = ((lit && !dead_win) ? (NUM_DIGITS'(1) << idx_q) : '0) ^ DIG_OFF;
  end

  always_ff @(posedge Clk_50MHz or posedge Reset) begin
    if (Reset) begin
      presc_q       <= '0;
      idx_q         <= IDX_MAX;
      code_q        <= '1;
      dp_q          <= '0;
      blink_q       <= '0;
      lz_q          <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pwm_q         <= '0;
      frame_done_q  <= 1'b0;
      duan_q        <= SEG_OFF;
      wei_q         <= DIG_OFF;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      code_q        <= code_d;
      dp_q          <= dp_d;
      blink_q       <= blink_d;
      lz_q          <= lz_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      pwm_q         <= pwm_d;
      frame_done_q  <= frame_done_d;
      duan_q        <= duan_d;
      wei_q         <= wei_d;
    end
  end

  assign Duan       = duan_q;
  assign Wei        = wei_q;
  assign Frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: arithmetic reference model plus literal spot checks.
// Honours SEG_SCAN_DEADTIME_EN when the design is built with it.
module tb_seg_scan_ctrl;

  localparam int N  = 8;
  localparam int SD = 4;
  localparam int BF = 2;
  localparam int DC = 2;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic [31:0] Bcd_in = 32'h0;
  logic [7:0]  Dp_in = 8'h0;
  logic        Blank_lz = 1'b0;
  logic [7:0]  Blink_mask = 8'h0;
  logic [2:0]  Bright = 3'd7;
  logic [7:0]  Duan;
  logic [7:0]  Wei;
  logic        Frame_done;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  seg_scan_ctrl #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_FRAMES(BF), .PWM_BITS(3),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1), .DEAD_CYCLES(DC)
  ) dut (
    .Clk_50MHz(clk), .Reset(Reset), .Enable(Enable), .Bcd_in(Bcd_in), .Dp_in(Dp_in),
    .Blank_lz(Blank_lz), .Blink_mask(Blink_mask), .Bright(Bright),
    .Duan(Duan), .Wei(Wei), .Frame_done(Frame_done)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] c);
    case (c)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;  4'd3: return 7'h4F;
      4'd4: return 7'h66;  4'd5: return 7'h6D;  4'd6: return 7'h7D;  4'd7: return 7'h07;
      4'd8: return 7'h7F;  4'd9: return 7'h6F;  4'd10: return 7'h40; 4'd11: return 7'h79;
      4'd12: return 7'h50; 4'd13: return 7'h76; default: return 7'h00;
    endcase
  endfunction

  // Reference model: n = enabled clocks since reset, L = frames loaded so far.
  int         n, L;
  logic [3:0] s_code [N];
  logic [7:0] s_dp, s_blink, s_lz;
  logic [7:0] e_duan, e_wei;
  logic       e_fd;

  task automatic m_reset();
    n = 0;
    L = 0;
    for (int d = 0; d < N; d++) s_code[d] = 4'hF;
    s_dp = '0; s_blink = '0; s_lz = '0;
    e_duan = 8'hFF; e_wei = 8'hFF; e_fd = 1'b0;
  endtask

  task automatic m_step();
    int ticks, idx, presc, ph;
    bit lit, dead, load;
    logic [7:0] pat;
    ticks = n / SD;
    idx   = (N - 1 + ticks) % N;
    presc = n % SD;
    ph    = (L == 0) ? 0 : ((L - 1) / BF) % 2;
    lit   = Enable && !(ph == 1 && s_blink[idx]) && ((n % 8) <= int'(Bright));
    dead  = 1'b0;
`ifdef SEG_SCAN_DEADTIME_EN
    dead  = (presc < DC);
`endif
    pat    = {s_dp[idx], s_lz[idx] ? 7'h00 : seg_of(s_code[idx])};
    e_duan = lit ? ~pat : 8'hFF;
    e_wei  = (lit && !dead) ? ~(8'h01 << idx) : 8'hFF;
    load   = Enable && (presc == SD - 1) && (ticks % N == 0);
    e_fd   = load;
    if (load) begin
      for (int d = 0; d < N; d++) s_code[d] = Bcd_in[4*d +: 4];
      s_dp = Dp_in;
      s_blink = Blink_mask;
      s_lz = '0;
      if (Blank_lz) begin
        for (int d = N - 1; d >= 1; d--) begin
          if (Bcd_in[4*d +: 4] != 4'h0) break;
          s_lz[d] = 1'b1;
        end
      end
      L++;
    end
    if (Enable) n++;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge Reset);
      if (Reset) m_reset();
      else m_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("model_duan", Duan, e_duan);
      check("model_wei", Wei, e_wei);
      check("model_frame_done", Frame_done, e_fd);
    end
  end

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (Frame_done) return;
    end
    total++;
    bad++;
    $display("FAIL wait_fd: frame_done got 0 expected 1 within 200 cycles at %0t", $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 Reset = 1'b1;
    #1;
    check("rst_duan", Duan, 8'hFF);
    check("rst_wei", Wei, 8'hFF);
    check("rst_fd", Frame_done, 1'b0);
    @(negedge clk);
    Reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    int z;
    v = $urandom;
    z = $urandom_range(0, 8);
    if (z == 8) v = 32'h0;
    else v = v & (32'hFFFF_FFFF >> (4 * z));
    return v;
  endfunction

  initial begin
    int cnt;
    Enable = 1'b1;
    Bright = 3'd7;
    Bcd_in = 32'h1234_5678;
    step(2);
    chk_en = 1'b1;
    check("reset_duan", Duan, 8'hFF);
    check("reset_wei", Wei, 8'hFF);
    check("reset_fd", Frame_done, 1'b0);
    Reset = 1'b0;

    // basic scan
    step(4);  check("t1_first_fd", Frame_done, 1'b1);
    step(3);  check("t1_wei_d0", Wei, 8'hFE); check("t1_duan_d0", Duan, 8'h80);
    step(4);  check("t1_wei_d1", Wei, 8'hFD); check("t1_duan_d1", Duan, 8'hF8);
    step(24); check("t1_fd_before", Frame_done, 1'b0);
    step(1);  check("t1_fd_period", Frame_done, 1'b1);

    // leading-zero suppression
    Blank_lz = 1'b1;
    Bcd_in = 32'h0000_0042;
    wait_fd(); wait_fd();
    step(3); check("t2_wei_d0", Wei, 8'hFE); check("t2_duan_d0", Duan, 8'hA4);
    step(4); check("t2_wei_d1", Wei, 8'hFD); check("t2_duan_d1", Duan, 8'h99);
    step(4); check("t2_wei_d2", Wei, 8'hFB); check("t2_duan_d2", Duan, 8'hFF);
    Bcd_in = 32'h0;
    wait_fd(); wait_fd();
    step(3); check("t2_zero_d0", Duan, 8'hC0);
    step(4); check("t2_zero_d1", Duan, 8'hFF);

    // frame coherence
    Blank_lz = 1'b0;
    Bcd_in = 32'h1234_5678;
    wait_fd(); wait_fd();
    step(15); check("t3_slot3", Duan, 8'h92);
    Bcd_in = 32'h0;
    step(4); check("t3_slot4_old", Duan, 8'h99);
    wait_fd();
    step(19); check("t3_slot4_new", Duan, 8'hC0);

    // blink
    Bcd_in = 32'h1234_5678;
    Blink_mask = 8'h03;
    do_reset();
    wait_fd(); wait_fd(); wait_fd();
    step(3); check("t4_dark_wei", Wei, 8'hFF); check("t4_dark_duan", Duan, 8'hFF);
    step(8); check("t4_d2_wei", Wei, 8'hFB); check("t4_d2_duan", Duan, 8'h82);
    wait_fd(); wait_fd();
    step(3); check("t4_lit_wei", Wei, 8'hFE); check("t4_lit_duan", Duan, 8'h80);

    // PWM and dead time
    Blink_mask = 8'h00;
    wait_fd(); wait_fd();
`ifndef SEG_SCAN_DEADTIME_EN
    Bright = 3'd2;
    step(1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin step(1); if (Wei !== 8'hFF) cnt++; end
    check("t5_pwm_bright2", cnt, 3);
    Bright = 3'd7;
    step(1);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin step(1); if (Wei !== 8'hFF) cnt++; end
    check("t5_pwm_bright7", cnt, 8);
`else
    wait_fd();
    step(1); check("t6_dead0", Wei, 8'hFF);
    step(1); check("t6_dead1", Wei, 8'hFF);
    step(1); check("t6_live", Wei, 8'hFE);
`endif

    // enable low and reset mid-slot
    Enable = 1'b0;
    step(1); check("t6_en_duan", Duan, 8'hFF); check("t6_en_wei", Wei, 8'hFF);
    step(6); check("t6_en_fd", Frame_done, 1'b0);
    Enable = 1'b1;
    step(5);
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 19) == 0) Bcd_in = rand_bcd();
      if ($urandom_range(0, 29) == 0) Dp_in = 8'($urandom);
      if ($urandom_range(0, 39) == 0) Blink_mask = 8'($urandom);
      if ($urandom_range(0, 29) == 0) Blank_lz = 1'($urandom);
      if ($urandom_range(0, 49) == 0) Bright = 3'($urandom);
      Enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 699) == 0) do_reset();
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
